// File: rtl/i2c_rx_buffer.sv
// -----------------------------------------------------------------------------
// i2c_rx_buffer
//   Launches multi-byte read transactions on an I2C master receive stage and
//   buffers every received byte, tagged with an end-of-transaction flag, in a
//   FIFO that drains over a valid/ready stream.
//
//   Admission control only starts a read when the FIFO has room for all of its
//   bytes. A watchdog aborts a stalled read, and clr flushes everything.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   rd_req, rd_len    one-cycle read request and its byte count (1..15)
//   clr               synchronous flush (FIFO, stickies, FSM)
//   i2c_ready         one-cycle start strobe to the receiver
//   i2c_data_bytes    byte count presented to the receiver
//   i2c_data          receiver byte
//   i2c_data_valid    receiver byte-valid level (rising edge = one byte)
//   m_data, m_last    head-of-FIFO byte and its end-of-transaction flag
//   m_valid, m_ready  stream handshake
//   fifo_count        entries currently stored
//   busy              a transaction is in progress
//   done              one-cycle pulse: transaction completed and stored
//   err               one-cycle pulse: rd_req rejected
//   timeout           sticky: watchdog aborted a transaction
// -----------------------------------------------------------------------------
module i2c_rx_buffer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [3:0]    rd_len,
  input  logic          clr,
  output logic          i2c_ready,
  output logic [3:0]    i2c_data_bytes,
  input  logic [7:0]    i2c_data,
  input  logic          i2c_data_valid,
  output logic [7:0]    m_data,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  head;
  logic        valid_q;
  logic [3:0]  byte_cnt;
  logic [15:0] wd_cnt;
  logic        timeout_q;

  logic        full;
  logic [AW:0] free_space;
  logic        admit, accept, byte_event, is_last, wd_fire, push, pop;

  // ---------------------------------------------------------------------------
  // FIFO status and control decodes
  // ---------------------------------------------------------------------------
  assign fifo_count = wr_ptr - rd_ptr;
  assign m_valid    = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign free_space = (AW+1)'(DEPTH) - fifo_count;

  assign admit      = (rd_len != 4'd0) && (free_space >= (AW+1)'(rd_len));
  assign accept     = (state == S_IDLE) && rd_req && admit && !clr;
  // Rising edge of the receiver's valid level, counted only while waiting.
  assign byte_event = (state == S_WAIT) && i2c_data_valid && !valid_q;
  assign is_last    = (byte_cnt == i2c_data_bytes - 4'd1);
  assign wd_fire    = (state == S_WAIT) && !byte_event &&
                      (wd_cnt == 16'(TIMEOUT - 1));
  // Admission reserves the space, so full on push is an invariant violation;
  // the byte is dropped rather than corrupting the oldest entry.
  assign push       = byte_event && !full && !clr;
  assign pop        = m_valid && m_ready && !clr;

  // Head entry is gated so the stream outputs read zero while empty.
  assign head   = mem[rd_ptr[AW-1:0]];
  assign m_data = m_valid ? head[7:0] : 8'h00;
  assign m_last = m_valid ? head[8]   : 1'b0;

  assign timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned
    // (which would infer a latch).
    state_nx = state;
    if (clr) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_nx = S_REQ;
        S_REQ:  state_nx = S_WAIT;
        S_WAIT: begin
          if (byte_event && is_last) state_nx = S_DONE;
          else if (wd_fire)          state_nx = S_IDLE;
        end
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    i2c_ready = (state == S_REQ);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE) && !clr;
    err       = (state == S_IDLE) && rd_req && !admit && !clr;
  end

  // ---------------------------------------------------------------------------
  // Datapath: pointers, counters, stickies
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      i2c_data_bytes <= 4'd0;
      byte_cnt       <= 4'd0;
      wd_cnt         <= 16'd0;
      timeout_q      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      valid_q <= i2c_data_valid;

      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        if (accept)       timeout_q <= 1'b0;
        else if (wd_fire) timeout_q <= 1'b1;
      end

      // Watchdog clears on REQ entry and on every byte, counts in WAIT.
      if (accept) begin
        i2c_data_bytes <= rd_len;
        byte_cnt       <= 4'd0;
        wd_cnt         <= 16'd0;
      end else if (byte_event) begin
        byte_cnt <= byte_cnt + 4'd1;
        wd_cnt   <= 16'd0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // alone, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {is_last, i2c_data};
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(byte_event && full && !clr));

endmodule
